// File: rtl/nested_loop_walker_if.sv
// Job/result handshake bundle for nested_loop_walker.
// out_cycles exists only when NLW_CYCLE_COUNT_EN is defined.
interface nested_loop_walker_if #(
    parameter int OW = 2,
    parameter int IW = 2,
    parameter int CW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] in_outer_limit;
    logic [IW-1:0] in_inner_limit;
    logic          in_break_en;
    logic [OW-1:0] in_break_i;
    logic [IW-1:0] in_break_j;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_value;
`ifdef NLW_CYCLE_COUNT_EN
    logic [CW+OW-1:0] out_cycles;
`endif

    modport master (
        output in_valid, in_outer_limit, in_inner_limit, in_break_en, in_break_i, in_break_j,
        output out_ready,
        input  in_ready, out_valid, out_value
`ifdef NLW_CYCLE_COUNT_EN
        , input out_cycles
`endif
    );

    modport slave (
        input  in_valid, in_outer_limit, in_inner_limit, in_break_en, in_break_i, in_break_j,
        input  out_ready,
        output in_ready, out_valid, out_value
`ifdef NLW_CYCLE_COUNT_EN
        , output out_cycles
`endif
    );
endinterface

// File: rtl/nested_loop_walker.sv
// Multi-cycle nested-loop walker: one loop step per clock, break exits inner loop only.
// Optional RUN-cycle counter output enabled by NLW_CYCLE_COUNT_EN.
module nested_loop_walker #(
    parameter int OW = 2,
    parameter int IW = 2,
    parameter int CW = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nested_loop_walker_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    // One extra bit so i+1 / j+1 never wrap back into range
    logic [OW:0]   i_q, i_d;
    logic [IW:0]   j_q, j_d;
    logic [CW-1:0] count_q, count_d;
    logic [OW-1:0] ol_q, ol_d, bi_q, bi_d;
    logic [IW-1:0] il_q, il_d, bj_q, bj_d;
    logic          be_q, be_d;
`ifdef NLW_CYCLE_COUNT_EN
    logic [CW+OW-1:0] cyc_q, cyc_d;
`endif

    logic outer_done, inner_step;
    assign outer_done = i_q >= {1'b0, ol_q};
    assign inner_step = (j_q < {1'b0, il_q}) &&
                        !(be_q && (i_q == {1'b0, bi_q}) && (j_q == {1'b0, bj_q}));

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        count_d = count_q;
        ol_d    = ol_q;
        il_d    = il_q;
        be_d    = be_q;
        bi_d    = bi_q;
        bj_d    = bj_q;
`ifdef NLW_CYCLE_COUNT_EN
        cyc_d   = cyc_q;
`endif
        case (state_q)
            IDLE: if (bus.in_valid) begin
                ol_d    = bus.in_outer_limit;
                il_d    = bus.in_inner_limit;
                be_d    = bus.in_break_en;
                bi_d    = bus.in_break_i;
                bj_d    = bus.in_break_j;
                i_d     = '0;
                j_d     = '0;
                count_d = '0;
`ifdef NLW_CYCLE_COUNT_EN
                cyc_d   = '0;
`endif
                state_d = RUN;
            end
            RUN: begin
`ifdef NLW_CYCLE_COUNT_EN
                cyc_d = cyc_q + (CW+OW)'(1);
`endif
                if (outer_done) begin
                    state_d = DONE;
                end else if (inner_step) begin
                    count_d = count_q + CW'(1);
                    j_d     = j_q + (IW+1)'(1);
                end else begin
                    i_d = i_q + (OW+1)'(1);
                    j_d = '0;
                end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            count_q <= '0;
            ol_q    <= '0;
            il_q    <= '0;
            be_q    <= 1'b0;
            bi_q    <= '0;
            bj_q    <= '0;
`ifdef NLW_CYCLE_COUNT_EN
            cyc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            count_q <= count_d;
            ol_q    <= ol_d;
            il_q    <= il_d;
            be_q    <= be_d;
            bi_q    <= bi_d;
            bj_q    <= bj_d;
`ifdef NLW_CYCLE_COUNT_EN
            cyc_q   <= cyc_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_value = count_q;
`ifdef NLW_CYCLE_COUNT_EN
    assign bus.out_cycles = cyc_q;
`endif
endmodule

// File: tb/tb_nested_loop_walker.sv
// Scoreboard bench for nested_loop_walker: expected results queued at job issue, checked at output.
module tb_nested_loop_walker;
    localparam int OW = 2, IW = 2, CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nested_loop_walker_if #(.OW(OW), .IW(IW), .CW(CW)) bus ();
    nested_loop_walker #(.OW(OW), .IW(IW), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct { int value; int cycles; } exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Reference: walk the loops directly; cycles = increments + one step per i + exit
    function automatic exp_t model(int ol, int il, bit be, int bi, int bj);
        exp_t e;
        int n = 0;
        for (int i = 0; i < ol; i++)
            for (int j = 0; j < il; j++) begin
                if (be && i == bi && j == bj) break;
                n++;
            end
        e.value  = n % (1 << CW);
        e.cycles = n + ol + 1;
        return e;
    endfunction

    task automatic drive_idle();
        bus.in_valid = 0; bus.out_ready = 0;
        bus.in_outer_limit = '0; bus.in_inner_limit = '0;
        bus.in_break_en = 0; bus.in_break_i = '0; bus.in_break_j = '0;
    endtask

    // Issue a job, wait for result, check value/latency, optional backpressure hold.
    task automatic run_job(string name, int ol, int il, bit be, int bi, int bj, int hold);
        exp_t e;
        int lat = 0;
        int v0;
        @(negedge clk);
        bus.in_outer_limit = OW'(ol); bus.in_inner_limit = IW'(il);
        bus.in_break_en = be; bus.in_break_i = OW'(bi); bus.in_break_j = IW'(bj);
        bus.in_valid = 1;
        sb.push_back(model(ol, il, be, bi, bj));
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL %s accept: in_ready=%b required 1", name, bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 0;
        // Scramble inputs mid-job; latched fields must not follow
        bus.in_outer_limit = '1; bus.in_inner_limit = '1; bus.in_break_en = ~be;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk); lat++;
        end
        e = sb.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || lat != e.cycles) begin
            errors++; $display("FAIL %s latency: got %0d cycles required %0d", name, lat, e.cycles);
        end
        checks++;
        if (int'(bus.out_value) != e.value) begin
            errors++; $display("FAIL %s value: got %0d required %0d", name, bus.out_value, e.value);
        end
`ifdef NLW_CYCLE_COUNT_EN
        checks++;
        if (int'(bus.out_cycles) != e.cycles) begin
            errors++; $display("FAIL %s out_cycles: got %0d required %0d", name, bus.out_cycles, e.cycles);
        end
`endif
        v0 = int'(bus.out_value);
        for (int k = 0; k < hold; k++) begin
            bus.in_valid = k[0];
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || int'(bus.out_value) != v0 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d: valid=%b value=%0d in_ready=%b required 1/%0d/0",
                         name, k, bus.out_valid, bus.out_value, bus.in_ready, v0);
            end
        end
        bus.in_valid = 0;
        bus.out_ready = 1;
        @(negedge clk);
        bus.out_ready = 0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL %s release: valid=%b in_ready=%b required 0/1", name, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic check_reset_vals(string name);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_value !== '0) begin
            errors++;
            $display("FAIL %s: in_ready=%b out_valid=%b out_value=%0d required 1/0/0",
                     name, bus.in_ready, bus.out_valid, bus.out_value);
        end
`ifdef NLW_CYCLE_COUNT_EN
        checks++;
        if (bus.out_cycles !== '0) begin
            errors++; $display("FAIL %s out_cycles: got %0d required 0", name, bus.out_cycles);
        end
`endif
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        check_reset_vals("reset");
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL idle_no_output: out_valid=%b required 0", bus.out_valid);
        end
    endtask

    task automatic test_break();
        run_job("brk_2x2_11", 2, 2, 1, 1, 1, 0);
        run_job("brk_3x3_11", 3, 3, 1, 1, 1, 0);
        run_job("nobrk_3x3", 3, 3, 0, 1, 1, 0);
        run_job("brk_outside", 2, 2, 1, 3, 0, 0);
        run_job("brk_3x3_00", 3, 3, 1, 0, 0, 0);
    endtask

    task automatic test_zero_limits();
        run_job("outer0", 0, 3, 0, 0, 0, 0);
        run_job("inner0", 2, 0, 0, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        run_job("backpressure", 2, 3, 0, 0, 0, 5);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        bus.in_outer_limit = 2'd3; bus.in_inner_limit = 2'd3; bus.in_break_en = 0;
        bus.in_valid = 1;
        @(negedge clk);
        bus.in_valid = 0;
        repeat (4) @(negedge clk);
        rst_n = 0;
        #1;
        check_reset_vals("reset_mid_run");
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check_reset_vals("after_reset");
        run_job("post_reset_2x2", 2, 2, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++)
            run_job("random", $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    endtask

    initial begin
        test_reset();
        test_break();
        test_zero_limits();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
